roulette_round_ctrl: RTL and testbench
======================================

ROULETTE_ROUND_CTRL -- requirements
Module: roulette_round_ctrl

Interface
REQ-001 Parameter START_BALANCE, default 10, SHALL set the balance loaded at reset (range 1..31).
REQ-002 Parameter SPIN_CYCLES, default 16, SHALL set the SPIN state length in cycles (range 1..255).
REQ-003 Parameter LFSR_SEED, default 5'b00001, SHALL set the LFSR value loaded at reset (nonzero).
REQ-004 Port Clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, SHALL be the synchronous, active-high reset.
REQ-006 Port startGame, input, 1, SHALL be a level sampled each cycle; high in IDLE requests a round.
REQ-007 Port bet_mode, input, 1, SHALL select the bet type: 0 = exact number, 1 = parity.
REQ-008 Port playerGuess, input, 5, SHALL hold the guess: number 1..31, or for parity bit0 (0 = even, 1 = odd).
REQ-009 Port playerBalance, output, 5, SHALL be the current registered balance.
REQ-010 Port result_num, output, 5, SHALL be the registered outcome of the last spin.
REQ-011 Port win / lose, output, 1 each, SHALL be registered outcome flags of the last round.
REQ-012 Port busy, output, 1, SHALL be high in SPIN, EVAL and PAYOUT.
REQ-013 Port round_done, output, 1, SHALL be a one-cycle pulse in the cycle after PAYOUT.
REQ-014 Port bet_err, output, 1, SHALL be a one-cycle pulse when a start request is rejected as invalid.
REQ-015 Port game_over, output, 1, SHALL be high while in state OVER.

Function
REQ-016 Internal 5-bit LFSR SHALL step every cycle outside reset: next = {lfsr[3:0], lfsr[4]^lfsr[2]}; it never reaches 0, so values are 1..31.
REQ-017 States SHALL be IDLE, SPIN, EVAL, PAYOUT, OVER.
REQ-018 IDLE: startGame=1 with a valid bet SHALL move to SPIN next cycle, clear win/lose and load spin counter with SPIN_CYCLES-1.
REQ-019 Bet is invalid when bet_mode=0 and playerGuess=0; startGame=1 then SHALL pulse bet_err for one cycle and remain in IDLE.
REQ-020 playerGuess and bet_mode SHALL be captured on the accepting cycle; later input changes in the round SHALL be ignored.
REQ-021 SPIN: counter decrements each cycle; in the cycle it reads 0, result_num SHALL take the current LFSR value and state SHALL go to EVAL; SPIN lasts exactly SPIN_CYCLES cycles.
REQ-022 EVAL (1 cycle): win SHALL be set if (mode 0 and guess == result_num) or (mode 1 and guess[0] == result_num[0]); otherwise lose SHALL be set.
REQ-023 PAYOUT (1 cycle): on win, balance SHALL become min(balance+2, 31); on lose, balance SHALL become balance-1.
REQ-024 After PAYOUT, state SHALL be OVER if the new balance is 0, else IDLE; round_done SHALL pulse in that next cycle.
REQ-025 Latency: start accepted at cycle t → result_num valid at t+SPIN_CYCLES+1, balance updated at t+SPIN_CYCLES+3, round_done high at cycle t+SPIN_CYCLES+3.
REQ-026 startGame while busy or in OVER SHALL be ignored (no bet_err, no state change).
REQ-027 startGame held high SHALL start a new round on each return to IDLE (back-to-back rounds, one IDLE cycle between).
REQ-028 OVER SHALL be absorbing; only reset exits it.
REQ-029 win, lose and result_num SHALL hold their values until the next accepted start.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, playerBalance=START_BALANCE, LFSR=LFSR_SEED, result_num=0, win=lose=busy=round_done=bet_err=game_over=0, in any state including mid-SPIN.
REQ-031 reset SHALL take priority over startGame in the same cycle.

Verification
REQ-032 Reset, mode 0, guess = model-predicted LFSR value at end of SPIN, start 1 cycle → win=1, balance 10→12, round_done at t+19.
REQ-033 Reset, mode 0, guess = predicted value+1 (≠ result) → lose=1, balance 10→9; ten consecutive losses → balance 0, game_over=1, further startGame ignored.
REQ-034 START_BALANCE=30, forced win → balance 31 (saturated); second win → stays 31.
REQ-035 Mode 0, guess=0, startGame=1 → bet_err single pulse, busy stays 0, balance unchanged at 10.
REQ-036 Reset asserted at SPIN cycle 5 → next cycle IDLE, busy=0, balance=10, LFSR=LFSR_SEED; startGame pulsed during SPIN has no effect on balance.
REQ-037 Mode 1, guess bit0 = predicted result_num[0] → win=1; opposite parity → lose=1.

Source files
------------

// File: rtl/roulette_round_ctrl.sv
// Roulette round controller: LFSR-driven spin, exact-number or parity bet,
// balance payout with saturation, and an absorbing game-over state.
module roulette_round_ctrl #(
  parameter int         START_BALANCE = 10,
  parameter int         SPIN_CYCLES   = 16,
  parameter logic [4:0] LFSR_SEED     = 5'b00001
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       startGame,
  input  logic       bet_mode,
  input  logic [4:0] playerGuess,
  output logic [4:0] playerBalance,
  output logic [4:0] result_num,
  output logic       win,
  output logic       lose,
  output logic       busy,
  output logic       round_done,
  output logic       bet_err,
  output logic       game_over
);

  typedef enum logic [2:0] {IDLE, SPIN, EVAL, PAYOUT, OVER} state_t;

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [4:0] lfsr;
  logic [4:0] guess, guess_next;
  logic       mode, mode_next;
  logic [4:0] bal_next, res_next;
  logic       win_next, lose_next, done_next, err_next;
  logic       hit;
  logic [5:0] bal_plus2;

  assign bal_plus2 = {1'b0, playerBalance} + 6'd2;
  assign busy      = (state == SPIN) || (state == EVAL) || (state == PAYOUT);
  assign game_over = (state == OVER);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    guess_next = guess;
    mode_next  = mode;
    res_next   = result_num;
    win_next   = win;
    lose_next  = lose;
    bal_next   = playerBalance;
    done_next  = 1'b0;
    err_next   = 1'b0;
    hit        = 1'b0;

    case (state)
      IDLE: begin
        if (startGame) begin
          if (!bet_mode && playerGuess == 5'd0) begin
            err_next = 1'b1;
          end else begin
            state_next = SPIN;
            cnt_next   = 8'(SPIN_CYCLES - 1);
            guess_next = playerGuess;
            mode_next  = bet_mode;
            win_next   = 1'b0;
            lose_next  = 1'b0;
          end
        end
      end
      SPIN: begin
        if (cnt == 8'd0) begin
          res_next   = lfsr;
          state_next = EVAL;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      EVAL: begin
        hit        = mode ? (guess[0] == result_num[0]) : (guess == result_num);
        win_next   = hit;
        lose_next  = !hit;
        state_next = PAYOUT;
      end
      PAYOUT: begin
        if (win) bal_next = (bal_plus2 > 6'd31) ? 5'd31 : bal_plus2[4:0];
        else     bal_next = playerBalance - 5'd1;
        done_next  = 1'b1;
        state_next = (bal_next == 5'd0) ? OVER : IDLE;
      end
      OVER:    state_next = OVER;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      lfsr          <= LFSR_SEED;
      guess         <= 5'd0;
      mode          <= 1'b0;
      playerBalance <= 5'(START_BALANCE);
      result_num    <= 5'd0;
      win           <= 1'b0;
      lose          <= 1'b0;
      round_done    <= 1'b0;
      bet_err       <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      lfsr          <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      guess         <= guess_next;
      mode          <= mode_next;
      playerBalance <= bal_next;
      result_num    <= res_next;
      win           <= win_next;
      lose          <= lose_next;
      round_done    <= done_next;
      bet_err       <= err_next;
    end
  end

endmodule

// File: tb/tb_roulette_round_ctrl.sv
// Randomized bench for roulette_round_ctrl: outcomes predicted from the LFSR
// recurrence and the payout rules, compared cycle-accurately against the DUT.
module tb_roulette_round_ctrl;

  localparam int         N    = 16;
  localparam logic [4:0] SEED = 5'b00001;

  typedef enum int {FORCE_WIN, FORCE_LOSE, RANDOM} want_t;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       startGame = 1'b0;
  logic       bet_mode = 1'b0;
  logic [4:0] playerGuess = 5'd1;

  logic [4:0] playerBalance, result_num;
  logic       win, lose, busy, round_done, bet_err, game_over;
  logic [4:0] bal30, res30;
  logic       win30, lose30, busy30, done30, err30, over30;

  roulette_round_ctrl #(.START_BALANCE(10), .SPIN_CYCLES(N), .LFSR_SEED(SEED)) dut (
    .Clock(Clock), .reset(reset), .startGame(startGame), .bet_mode(bet_mode),
    .playerGuess(playerGuess), .playerBalance(playerBalance), .result_num(result_num),
    .win(win), .lose(lose), .busy(busy), .round_done(round_done), .bet_err(bet_err),
    .game_over(game_over));

  roulette_round_ctrl #(.START_BALANCE(30), .SPIN_CYCLES(N), .LFSR_SEED(SEED)) dut30 (
    .Clock(Clock), .reset(reset), .startGame(startGame), .bet_mode(bet_mode),
    .playerGuess(playerGuess), .playerBalance(bal30), .result_num(res30),
    .win(win30), .lose(lose30), .busy(busy30), .round_done(done30), .bet_err(err30),
    .game_over(over30));

  always #5 Clock = ~Clock;

  int passed = 0;
  int total  = 0;

  // Reference state: LFSR value of the current cycle plus round outcome.
  logic [4:0] model_lfsr;
  logic [4:0] ref_bal, ref_bal30, ref_res;
  logic       ref_win, ref_lose;

  function automatic logic [4:0] step(input logic [4:0] v);
    return {v[3:0], v[4] ^ v[2]};
  endfunction

  function automatic logic [4:0] ahead(input logic [4:0] v, input int n);
    logic [4:0] x = v;
    for (int i = 0; i < n; i++) x = step(x);
    return x;
  endfunction

  function automatic logic [4:0] pay(input logic [4:0] bal, input logic won);
    int b = won ? int'(bal) + 2 : int'(bal) - 1;
    if (b > 31) b = 31;
    return 5'(b);
  endfunction

  always @(posedge Clock) model_lfsr <= reset ? SEED : step(model_lfsr);

  task automatic ref_after_reset();
    ref_bal = 5'd10; ref_bal30 = 5'd30; ref_res = 5'd0;
    ref_win = 1'b0;  ref_lose = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    reset = 1'b1; startGame = 1'b0;
    @(negedge Clock);
    reset = 1'b0;
    ref_after_reset();
  endtask

  task automatic play_round(input logic mode, input want_t want, input bit hold, input bit scramble);
    logic [4:0] pred, g;
    logic       exp_win;
    bit         early;
    total++; if (win !== ref_win || lose !== ref_lose || result_num !== ref_res) begin
      $display("FAIL hold_outcome: got win=%0b lose=%0b res=%0d want win=%0b lose=%0b res=%0d",
               win, lose, result_num, ref_win, ref_lose, ref_res);
    end else passed++;

    pred = ahead(model_lfsr, N);
    case (want)
      FORCE_WIN:  g = mode ? {5'($urandom) & 5'h1e} | {4'd0, pred[0]} : pred;
      FORCE_LOSE: g = mode ? {5'($urandom) & 5'h1e} | {4'd0, ~pred[0]}
                           : ((pred == 5'd31) ? 5'd1 : pred + 5'd1);
      default:    g = mode ? 5'($urandom) : 5'($urandom_range(1, 31));
    endcase
    exp_win = mode ? (g[0] == pred[0]) : (g == pred);
    bet_mode = mode; playerGuess = g; startGame = 1'b1;

    early = 1'b0;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge Clock);
      if (!hold) startGame = 1'b0;
      if (scramble && k < N + 3) begin
        bet_mode = 1'($urandom); playerGuess = 5'($urandom);
      end
      if (k == 1) begin
        total++; if (busy !== 1'b1) $display("FAIL busy_after_start: got %0b want 1", busy);
        else passed++;
      end
      if (k == N + 1) begin
        total++; if (result_num !== pred) $display("FAIL result_num: got %0d want %0d", result_num, pred);
        else passed++;
      end
      if (k < N + 3 && round_done) early = 1'b1;
    end

    ref_res   = pred;
    ref_win   = exp_win;
    ref_lose  = !exp_win;
    ref_bal   = pay(ref_bal, exp_win);
    ref_bal30 = pay(ref_bal30, exp_win);

    total++; if (round_done !== 1'b1 || early) $display("FAIL round_done_timing: got done=%0b early=%0b want done=1 early=0", round_done, early);
    else passed++;
    total++; if (win !== ref_win || lose !== ref_lose) $display("FAIL win_lose: got %0b/%0b want %0b/%0b", win, lose, ref_win, ref_lose);
    else passed++;
    total++; if (playerBalance !== ref_bal) $display("FAIL balance: got %0d want %0d", playerBalance, ref_bal);
    else passed++;
    total++; if (bal30 !== ref_bal30) $display("FAIL balance30: got %0d want %0d", bal30, ref_bal30);
    else passed++;
    total++; if (game_over !== (ref_bal == 5'd0)) $display("FAIL game_over: got %0b want %0b", game_over, ref_bal == 5'd0);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({playerBalance, bal30, result_num} !== {5'd10, 5'd30, 5'd0}) $display("FAIL reset_values: got bal=%0d bal30=%0d res=%0d want 10 30 0", playerBalance, bal30, result_num);
    else passed++;
    total++; if ({win, lose, busy, round_done, bet_err, game_over} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {win, lose, busy, round_done, bet_err, game_over});
    else passed++;
    // reset wins over a valid start in the same cycle
    @(negedge Clock);
    reset = 1'b1; startGame = 1'b1; bet_mode = 1'b0; playerGuess = 5'd3;
    @(negedge Clock);
    total++; if (busy !== 1'b0) $display("FAIL reset_priority: got busy=%0b want 0", busy);
    else passed++;
    reset = 1'b0; startGame = 1'b0;
    ref_after_reset();
  endtask

  task automatic test_exact_win();
    do_reset();
    play_round(1'b0, FORCE_WIN, 1'b0, 1'b0);
  endtask

  task automatic test_losses_to_over();
    bit bad;
    do_reset();
    for (int i = 0; i < 10; i++) play_round(1'b0, FORCE_LOSE, 1'b0, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      startGame = 1'b1; bet_mode = 1'($urandom); playerGuess = 5'($urandom_range(0, 3));
      @(negedge Clock);
      if (busy || bet_err || !game_over || playerBalance !== 5'd0) bad = 1'b1;
    end
    startGame = 1'b0;
    total++; if (bad) $display("FAIL over_absorbing: got busy=%0b err=%0b over=%0b bal=%0d want 0 0 1 0", busy, bet_err, game_over, playerBalance);
    else passed++;
  endtask

  task automatic test_saturate();
    do_reset();
    play_round(1'b0, FORCE_WIN, 1'b0, 1'b0);
    play_round(1'b1, FORCE_WIN, 1'b0, 1'b0);
    total++; if (bal30 !== 5'd31) $display("FAIL saturate31: got %0d want 31", bal30);
    else passed++;
  endtask

  task automatic test_bet_err();
    do_reset();
    @(negedge Clock);
    bet_mode = 1'b0; playerGuess = 5'd0; startGame = 1'b1;
    @(negedge Clock);
    startGame = 1'b0;
    total++; if (bet_err !== 1'b1 || busy !== 1'b0) $display("FAIL bet_err_pulse: got err=%0b busy=%0b want 1 0", bet_err, busy);
    else passed++;
    @(negedge Clock);
    total++; if (bet_err !== 1'b0 || busy !== 1'b0 || playerBalance !== 5'd10) $display("FAIL bet_err_after: got err=%0b busy=%0b bal=%0d want 0 0 10", bet_err, busy, playerBalance);
    else passed++;
  endtask

  task automatic test_reset_mid_spin();
    do_reset();
    bet_mode = 1'b0; playerGuess = 5'd7; startGame = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clock);
      startGame = (k == 3);
    end
    reset = 1'b1; startGame = 1'b0;
    @(negedge Clock);
    reset = 1'b0;
    ref_after_reset();
    total++; if (busy !== 1'b0 || playerBalance !== 5'd10 || result_num !== 5'd0 || win || lose) $display("FAIL mid_spin_reset: got busy=%0b bal=%0d res=%0d want 0 10 0", busy, playerBalance, result_num);
    else passed++;
    // a win predicted from the seed proves the LFSR was reloaded
    play_round(1'b0, FORCE_WIN, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    do_reset();
    play_round(1'b1, FORCE_WIN, 1'b0, 1'b0);
    play_round(1'b1, FORCE_LOSE, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) play_round(1'($urandom), RANDOM, 1'b1, 1'b1);
    startGame = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge Clock);
      play_round(1'($urandom), RANDOM, 1'b0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_exact_win();
    test_losses_to_over();
    test_saturate();
    test_bet_err();
    test_reset_mid_spin();
    test_parity();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
